// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC control, imem request/response handshake, redirect arbitration and flushes.
// Latency: redirect/flush/PC strobes are combinational; one request in flight, response accepted 1+ cycles after imem_ready.
// Backpressure: imem_req holds until imem_ready; stall_id parks the response in a 1-entry hold state; redirect beats stall.
module fetch_controller #(
    parameter logic [31:0] TRAP_ADDR = 32'h0000_0100,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      pc_current,
    output logic             pc_enable,
    output logic             pc_src,
    output logic [31:0]      pc_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_valid,
    input  logic             stall_id,
    output logic             if_valid,
    input  logic             trap,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             id_redirect,
    input  logic [31:0]      id_target,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]  state, state_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [1:0]  pend_prio, pend_prio_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;

    // Request priority: 3 = trap, 2 = EX, 1 = ID, 0 = none.
    logic [1:0]  req_prio;
    logic [31:0] req_tgt;
    logic        accept;

    always_comb begin
        req_prio = 2'd0;
        req_tgt  = 32'h0;
        if (trap) begin
            req_prio = 2'd3;
            req_tgt  = TRAP_ADDR;
        end else if (ex_redirect) begin
            req_prio = 2'd2;
            req_tgt  = ex_target;
        end else if (id_redirect) begin
            req_prio = 2'd1;
            req_tgt  = id_target;
        end
        req_tgt[1:0] = 2'b00;
    end

    // A lower-priority request arriving behind a pending one is ignored outright.
    assign accept     = (state != BOOT) && (req_prio != 2'd0) &&
                        (!pend_vld || (req_prio >= pend_prio));
    assign flush_ifid = accept;
    assign flush_idex = accept && (req_prio >= 2'd2);
    assign imem_addr  = imem_req ? pc_current : 32'h0;

    always_comb begin
        state_nxt     = state;
        pend_vld_nxt  = pend_vld;
        pend_prio_nxt = pend_prio;
        pend_tgt_nxt  = pend_tgt;
        pc_enable     = 1'b0;
        pc_src        = 1'b0;
        pc_target     = 32'h0;
        imem_req      = 1'b0;
        if_valid      = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (accept) begin
                    pc_enable = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = req_tgt;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    pend_vld_nxt  = 1'b0;
                    pend_prio_nxt = 2'd0;
                    pend_tgt_nxt  = 32'h0;
                    if (accept) begin
                        pc_enable = 1'b1;
                        pc_src    = 1'b1;
                        pc_target = req_tgt;
                        state_nxt = FETCH;
                    end else if (pend_vld) begin
                        pc_enable = 1'b1;
                        pc_src    = 1'b1;
                        pc_target = pend_tgt;
                        state_nxt = FETCH;
                    end else if (!stall_id) begin
                        if_valid  = 1'b1;
                        pc_enable = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HOLD;
                    end
                end else if (accept) begin
                    pend_vld_nxt  = 1'b1;
                    pend_prio_nxt = req_prio;
                    pend_tgt_nxt  = req_tgt;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_enable = 1'b1;
                    pc_src    = 1'b1;
                    pc_target = req_tgt;
                    state_nxt = FETCH;
                end else if (!stall_id) begin
                    if_valid  = 1'b1;
                    pc_enable = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= BOOT;
            pend_vld       <= 1'b0;
            pend_prio      <= 2'd0;
            pend_tgt       <= 32'h0;
            redirect_count <= '0;
        end else begin
            state     <= state_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_prio <= pend_prio_nxt;
            pend_tgt  <= pend_tgt_nxt;
            if (accept) redirect_count <= redirect_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected strobes are queued by the stimulus and popped by a monitor.
module tb_fetch_controller;

    logic        clock, reset_n;
    logic [31:0] pc_current, pc_target, imem_addr, ex_target, id_target;
    logic        pc_enable, pc_src, imem_req, imem_ready, imem_valid, stall_id;
    logic        if_valid, trap, ex_redirect, id_redirect, flush_ifid, flush_idex;
    logic [15:0] redirect_count;

    fetch_controller #(.TRAP_ADDR(32'h0000_0100), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .pc_current(pc_current),
        .pc_enable(pc_enable), .pc_src(pc_src), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .stall_id(stall_id), .if_valid(if_valid),
        .trap(trap), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .id_redirect(id_redirect), .id_target(id_target),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .redirect_count(redirect_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External PC register, reset alongside the controller.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)      pc_current <= 32'h0;
        else if (pc_enable) pc_current <= pc_src ? pc_target : pc_current + 32'd4;
    end

    typedef struct packed {
        logic        ifv, pce, src, fi, fx;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic ifv, pce, src, input logic [31:0] tgt, input logic fi, fx);
        exp_t e;
        e.ifv = ifv; e.pce = pce; e.src = src; e.tgt = tgt; e.fi = fi; e.fx = fx;
        q.push_back(e);
    endtask

    task automatic next_cyc;
        @(posedge clock);
        #1;
    endtask

    // Monitor: any strobe cycle must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t act, e;
        if (if_valid || pc_enable || flush_ifid) begin
            act = '{if_valid, pc_enable, pc_src, flush_ifid, flush_idex, pc_target};
            if (q.size() == 0) begin
                check("unexpected_strobe", 64'(act), 64'h0);
            end else begin
                e = q.pop_front();
                check("strobe", 64'(act), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; imem_ready = 1'b0; imem_valid = 1'b0; stall_id = 1'b0;
        trap = 1'b0; ex_redirect = 1'b0; id_redirect = 1'b0;
        ex_target = 32'h0; id_target = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_outs", 64'({imem_req, pc_enable, pc_src, if_valid, flush_ifid, flush_idex}), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h0);
        check("rst_tgt", 64'(pc_target), 64'h0);
        check("rst_cnt", 64'(redirect_count), 64'h0);
        next_cyc();
        reset_n = 1'b1;
        @(negedge clock); check("boot_req", 64'(imem_req), 64'h0);
        next_cyc();

        // Sequential fetch: FETCH, WAIT repeating.
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1; imem_valid = 1'b0;
            @(negedge clock);
            check("seq_req", 64'(imem_req), 64'h1);
            check("seq_addr", 64'(imem_addr), 64'(4 * i));
            next_cyc();
            imem_valid = 1'b1;
            push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clock); check("seq_wait_req", 64'(imem_req), 64'h0);
            next_cyc();
        end

        // EX redirect in FETCH.
        imem_valid = 1'b0; imem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0043;
        push(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
        @(negedge clock); check("ex_req", 64'(imem_req), 64'h0);
        next_cyc();
        ex_redirect = 1'b0; imem_ready = 1'b1;
        @(negedge clock);
        check("ex_cnt", 64'(redirect_count), 64'h1);
        check("ex_addr", 64'(imem_addr), 64'h40);
        next_cyc();

        // Trap+EX+ID in WAIT, lower-priority ID afterwards, response 3 cycles later.
        imem_ready = 1'b0; trap = 1'b1; ex_redirect = 1'b1; ex_target = 32'h200;
        id_redirect = 1'b1; id_target = 32'h300;
        push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clock); next_cyc();
        trap = 1'b0; ex_redirect = 1'b0;
        @(negedge clock); check("pend_low_prio_flush", 64'(flush_ifid), 64'h0);
        next_cyc();
        id_redirect = 1'b0;
        @(negedge clock); next_cyc();
        imem_valid = 1'b1;
        push(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        @(negedge clock); check("pend_drop_ifv", 64'(if_valid), 64'h0);
        next_cyc();
        imem_valid = 1'b0; imem_ready = 1'b1;
        @(negedge clock);
        check("trap_cnt", 64'(redirect_count), 64'h2);
        check("trap_addr", 64'(imem_addr), 64'h100);
        next_cyc();

        // Response under stall: 4 stalled cycles, then release.
        imem_ready = 1'b0; imem_valid = 1'b1; stall_id = 1'b1;
        @(negedge clock); check("stall_pce", 64'(pc_enable), 64'h0);
        next_cyc();
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_quiet", 64'({pc_enable, if_valid, imem_req}), 64'h0);
            next_cyc();
        end
        stall_id = 1'b0;
        push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock); next_cyc();

        // imem_ready low for 5 cycles in FETCH.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("rdy_lo_req_addr", 64'({imem_req, imem_addr}), {31'h0, 1'b1, 32'h104});
            check("rdy_lo_pce", 64'(pc_enable), 64'h0);
            next_cyc();
        end
        imem_ready = 1'b1;
        @(negedge clock); check("rdy_hi_addr", 64'(imem_addr), 64'h104);
        next_cyc();
        imem_ready = 1'b0; imem_valid = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock); next_cyc();

        // ID-only redirect in FETCH: no ID/EX flush.
        imem_valid = 1'b0; id_redirect = 1'b1; id_target = 32'h0000_0207;
        push(1'b0, 1'b1, 1'b1, 32'h0000_0204, 1'b1, 1'b0);
        @(negedge clock); next_cyc();
        id_redirect = 1'b0; imem_ready = 1'b1;
        @(negedge clock);
        check("id_cnt", 64'(redirect_count), 64'h3);
        check("id_addr", 64'(imem_addr), 64'h204);
        next_cyc();

        // Asynchronous reset while in WAIT, with a trap pending on the inputs.
        imem_ready = 1'b0; trap = 1'b1; reset_n = 1'b0;
        #1;
        check("arst_outs", 64'({imem_req, pc_enable, pc_src, if_valid, flush_ifid, flush_idex}), 64'h0);
        check("arst_cnt", 64'(redirect_count), 64'h0);
        next_cyc();
        trap = 1'b0; reset_n = 1'b1;
        @(negedge clock); check("reboot_req", 64'(imem_req), 64'h0);
        next_cyc();
        @(negedge clock);
        check("refetch_req_addr", 64'({imem_req, imem_addr}), {31'h0, 1'b1, 32'h0});
        check("refetch_cnt", 64'(redirect_count), 64'h0);
        check("queue_drained", 64'(q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction-fetch stage of the 5-stage pipeline.
- Drives the program counter's enable, source-select and target inputs, and runs the instruction-memory request/response handshake.
- Arbitrates redirect requests from trap logic, EX (branch/jalr) and ID (jal), and emits pipeline flushes.
- Sits between the program counter, the instruction-memory port, the hazard unit and the IF/ID register.

Parameters:
- TRAP_ADDR, 32'h00000100, redirect target used when trap is asserted.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pc_current  in  32  current PC value
- pc_enable  out  1  PC update strobe
- pc_src  out  1  0 = PC+4, 1 = pc_target
- pc_target  out  32  redirect address, bits [1:0] forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc_current)
- imem_ready  in  1  memory accepts request this cycle
- imem_valid  in  1  instruction response valid
- stall_id  in  1  hazard unit: IF/ID must hold
- if_valid  out  1  IF/ID captures the response this cycle
- trap  in  1  trap redirect request
- ex_redirect  in  1  EX taken branch/jalr
- ex_target  in  32  EX redirect address
- id_redirect  in  1  ID jal
- id_target  in  32  ID redirect address
- flush_ifid  out  1  invalidate IF/ID
- flush_idex  out  1  invalidate ID/EX
- redirect_count  out  CNT_W  count of accepted redirects

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=BOOT; pending flag and pending target cleared; redirect_count=0.
  - All outputs 0.
- Arbitration, combinational each cycle, priority trap > ex_redirect > id_redirect:
  - winning target is TRAP_ADDR, ex_target or id_target, with [1:0] zeroed.
  - id_redirect is ignored when either higher-priority request is present.
- An accepted redirect asserts:
  - flush_ifid=1 in the same cycle;
  - flush_idex=1 only for trap or ex_redirect;
  - redirect_count+1 on the next edge (wraps at all-ones).
- States:
  - BOOT:
    - one idle cycle after reset release; imem_req=0.
    - next: FETCH.
  - FETCH:
    - imem_req=1, imem_addr=pc_current.
    - imem_req and imem_addr stay stable until imem_ready.
    - If a redirect is present: imem_req=0, pc_enable=1, pc_src=1, pc_target=winner; stay FETCH.
    - Else on imem_ready: go WAIT.
  - WAIT:
    - imem_req=0. Await imem_valid.
    - Redirect with no imem_valid: latch pending=1 and the target; assert flushes now.
    - Later redirects while pending: overwrite only if higher or equal priority.
    - On imem_valid with pending or a same-cycle redirect:
      - if_valid=0 (response discarded);
      - pc_enable=1, pc_src=1 with the pending/winning target;
      - clear pending; go FETCH.
    - On imem_valid with no redirect and stall_id=0: if_valid=1, pc_enable=1, pc_src=0; go FETCH.
    - On imem_valid with no redirect and stall_id=1: capture the response into a 1-entry hold buffer; go HOLD.
  - HOLD:
    - imem_req=0; if_valid=0 while stall_id=1.
    - When stall_id falls: if_valid=1 (buffered instruction), pc_enable=1, pc_src=0; go FETCH.
    - A redirect in HOLD: drop the buffer, pc_enable=1, pc_src=1; go FETCH.
- Invariants:
  - At most one outstanding memory request.
  - pc_enable is never asserted in BOOT.
  - pc_enable=1 occurs at most once per fetched instruction or redirect.
- The redirect-vs-stall priority rule: redirect always wins over stall_id.
- Reset mid-operation:
  - outstanding request abandoned; pending and buffer cleared.
  - The PC register is reset independently by the top level.

Test Plan:
- Sequential fetch: imem_ready=1, imem_valid one cycle after accept, no stalls -> pattern FETCH,WAIT repeats; pc_enable pulses every 2nd cycle with pc_src=0; if_valid=1 on each response.
- EX redirect in FETCH: ex_redirect=1, ex_target=32'h0000_0043 -> same cycle imem_req=0, pc_src=1, pc_target=32'h0000_0040, flush_ifid=1, flush_idex=1; redirect_count=1.
- Simultaneous trap+ex+id in WAIT, imem_valid 3 cycles later -> pending target=TRAP_ADDR (0x100); the response is dropped (if_valid=0); PC is loaded with 0x100 on the imem_valid cycle.
- Stall during response: imem_valid with stall_id=1 for 4 cycles -> HOLD; no pc_enable and no if_valid for 4 cycles; then if_valid=1 and pc_enable=1 in the cycle stall_id falls.
- imem_ready low 5 cycles in FETCH -> imem_req and imem_addr held stable; no pc_enable until after the response.
- Assert reset_n=0 asynchronously while in WAIT -> outputs 0 immediately; after release, one BOOT cycle, then imem_req=1; redirect_count=0.
